// File: rtl/seq_muldiv_unit.sv
// Iterative signed/unsigned multiply and divide engine with a start/busy/done handshake.
// One iteration per cycle: done lands WIDTH+2 cycles after accept, or 2 cycles for divide-by-zero.
module seq_muldiv_unit #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] OP_SMUL = 2'b00;
  localparam logic [1:0] OP_UMUL = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d;          // multiplicand or divisor magnitude
  logic [WIDTH:0]   acc_q, acc_d;      // upper product half or partial remainder
  logic [WIDTH-1:0] q_q, q_d;          // multiplier or dividend/quotient
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   umul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic             fix_dz;
  logic [WIDTH-1:0] quo_fixed;
  logic [WIDTH-1:0] rem_fixed;

  always_comb begin
    m_ext     = {m_q[WIDTH-1], m_q};
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    umul_sum  = acc_q + (q_q[0] ? {1'b0, m_q} : '0);
    // Remainder is always below the divisor, so one extra bit absorbs the shift.
    div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    div_fits  = (div_shift >= {1'b0, m_q});
    fix_dz    = op_q[1] && (m_q == '0);
    quo_fixed = quo_neg_q ? -q_q : q_q;
    rem_fixed = rem_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    m_d         = m_q;
    acc_d       = acc_q;
    q_d         = q_q;
    qm1_d       = qm1_q;
    a_raw_d     = a_raw_q;
    quo_neg_d   = quo_neg_q;
    rem_neg_d   = rem_neg_q;
    result_hi_d = result_hi_q;
    result_lo_d = result_lo_q;
    div_zero_d  = div_zero_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d       = op;
          a_raw_d    = a;
          cnt_d      = CNT_W'(WIDTH);
          div_zero_d = 1'b0;
          acc_d      = '0;
          qm1_d      = 1'b0;
          quo_neg_d  = 1'b0;
          rem_neg_d  = 1'b0;
          case (op)
            OP_SMUL, OP_UMUL: begin
              m_d = a;
              q_d = b;
            end
            OP_UDIV: begin
              m_d = b;
              q_d = a;
            end
            default: begin
              m_d       = b[WIDTH-1] ? -b : b;
              q_d       = a[WIDTH-1] ? -a : a;
              quo_neg_d = a[WIDTH-1] ^ b[WIDTH-1];
              rem_neg_d = a[WIDTH-1];
            end
          endcase
          state_d = (op[1] && (b == '0)) ? S_FIX : S_CALC;
        end
      end

      S_CALC: begin
        case (op_q)
          OP_SMUL: begin
            acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
            q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
            qm1_d = q_q[0];
          end
          OP_UMUL: begin
            acc_d = {1'b0, umul_sum[WIDTH:1]};
            q_d   = {umul_sum[0], q_q[WIDTH-1:1]};
          end
          default: begin
            acc_d = div_fits ? (div_shift - {1'b0, m_q}) : div_shift;
            q_d   = {q_q[WIDTH-2:0], div_fits};
          end
        endcase
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        if (fix_dz) begin
          result_hi_d = a_raw_q;
          result_lo_d = '1;
          div_zero_d  = 1'b1;
        end else if (op_q == OP_SDIV) begin
          result_hi_d = rem_fixed;
          result_lo_d = quo_fixed;
        end else begin
          result_hi_d = acc_q[WIDTH-1:0];
          result_lo_d = q_q;
        end
        state_d = S_DONE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      a_raw_q     <= '0;
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      result_hi_q <= '0;
      result_lo_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      a_raw_q     <= a_raw_d;
      quo_neg_q   <= quo_neg_d;
      rem_neg_q   <= rem_neg_d;
      result_hi_q <= result_hi_d;
      result_lo_q <= result_lo_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign done      = (state_q == S_DONE);
  assign div_zero  = div_zero_q;
  assign result_hi = result_hi_q;
  assign result_lo = result_lo_q;

endmodule

// File: tb/tb_seq_muldiv_unit.sv
// Self-checking bench for seq_muldiv_unit at WIDTH=16: directed vector table,
// randomized operations against an arithmetic model, and handshake corner sequences.
module tb_seq_muldiv_unit;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] result_hi;
  logic [W-1:0] result_lo;

  seq_muldiv_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero),
    .result_hi (result_hi),
    .result_lo (result_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int base    = 0;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Result computed straight from integer arithmetic: {div_zero, hi, lo}.
  function automatic logic [2*W:0] model(input logic [1:0] mop, input logic [W-1:0] ma,
                                         input logic [W-1:0] mb);
    longint p, sa, sb, qq, rr;
    logic [2*W-1:0] pw;
    case (mop)
      2'b00: begin
        p  = longint'($signed(ma)) * longint'($signed(mb));
        pw = p[2*W-1:0];
        return {1'b0, pw};
      end
      2'b01: begin
        p  = longint'(ma) * longint'(mb);
        pw = p[2*W-1:0];
        return {1'b0, pw};
      end
      default: begin
        if (mb == '0) return {1'b1, ma, {W{1'b1}}};
        if (mop == 2'b10) begin
          sa = longint'(ma);
          sb = longint'(mb);
        end else begin
          sa = longint'($signed(ma));
          sb = longint'($signed(mb));
        end
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[W-1:0], qq[W-1:0]};
      end
    endcase
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] lop, input logic [W-1:0] la, input logic [W-1:0] lb);
    int guard = 0;
    while ((busy || done) && guard < 100) begin
      advance();
      guard++;
    end
    base  = cyc;
    start = 1'b1;
    op    = lop;
    a     = la;
    b     = lb;
    advance();
    start = 1'b0;
    op    = 2'($urandom);
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_done(output int lat, output int bcnt, output int ovl);
    lat  = -1;
    bcnt = 0;
    ovl  = 0;
    for (int i = 0; i < 200; i++) begin
      if (busy) bcnt++;
      if (busy && done) ovl++;
      if (done) begin
        lat = cyc - base;
        break;
      end
      advance();
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] rop, input logic [W-1:0] ra,
                        input logic [W-1:0] rb, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz);
    int lat, bcnt, ovl, elat;
    elat = edz ? 2 : W + 2;
    launch(rop, ra, rb);
    wait_done(lat, bcnt, ovl);
    check({tag, " latency"}, 32'(lat), 32'(elat));
    check({tag, " busy cycles"}, 32'(bcnt), 32'(elat - 1));
    check({tag, " busy&done"}, 32'(ovl), 32'd0);
    check({tag, " hi"}, 32'(result_hi), 32'(ehi));
    check({tag, " lo"}, 32'(result_lo), 32'(elo));
    check({tag, " div_zero"}, 32'(div_zero), 32'(edz));
  endtask

  initial begin
    logic [2*W:0] m;
    logic [W-1:0] ra, rb;
    logic [1:0]   rop;
    logic [W-1:0] specials [4];
    int lat, bcnt, ovl, nd;

    vecs[0] = '{2'b00, 16'd931,  16'd788,  16'h000B, 16'h31BC, 1'b0, 18};
    vecs[1] = '{2'b00, 16'hFE46, 16'd131,  16'hFFFF, 16'h1DD2, 1'b0, 18};
    vecs[2] = '{2'b00, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0, 18};
    vecs[3] = '{2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 18};
    vecs[4] = '{2'b00, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 1'b0, 18};
    vecs[5] = '{2'b10, 16'd3473, 16'd147,  16'd92,   16'd23,   1'b0, 18};
    vecs[6] = '{2'b11, 16'hF26F, 16'd147,  16'hFFA4, 16'hFFE9, 1'b0, 18};
    vecs[7] = '{2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 18};
    vecs[8] = '{2'b10, 16'd447,  16'd0,    16'h01BF, 16'hFFFF, 1'b1, 2};
    vecs[9] = '{2'b11, 16'h8000, 16'd0,    16'h8000, 16'hFFFF, 1'b1, 2};
    specials = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};

    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) advance();
    rst = 1'b0;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset div_zero", 32'(div_zero), 32'd0);
    check("reset hi", 32'(result_hi), 32'd0);
    check("reset lo", 32'(result_lo), 32'd0);

    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt, ovl);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d busy cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
      check($sformatf("vec%0d busy&done", i), 32'(ovl), 32'd0);
      check($sformatf("vec%0d hi", i), 32'(result_hi), 32'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 32'(result_lo), 32'(vecs[i].lo));
      check($sformatf("vec%0d div_zero", i), 32'(div_zero), 32'(vecs[i].dz));
    end

    // Results and div_zero hold after done; the next accepted start clears div_zero.
    advance();
    check("dz hold flag", 32'(div_zero), 32'd1);
    check("dz hold lo", 32'(result_lo), 32'h0000FFFF);
    launch(2'b01, 16'd3, 16'd5);
    check("dz cleared on start", 32'(div_zero), 32'd0);
    check("hold hi during calc", 32'(result_hi), 32'h00008000);
    wait_done(lat, bcnt, ovl);
    check("after dz lo", 32'(result_lo), 32'd15);

    // Start during the DONE cycle is ignored.
    start = 1'b1; op = 2'b01; a = 16'd7; b = 16'd7;
    advance();
    start = 1'b0;
    check("start in DONE ignored busy", 32'(busy), 32'd0);
    check("start in DONE ignored lo", 32'(result_lo), 32'd15);

    // Start pulsed while busy is ignored and does not disturb operands.
    launch(2'b00, 16'd931, 16'd788);
    while (cyc - base < 5) advance();
    start = 1'b1; op = 2'b01; a = 16'd1; b = 16'd1;
    advance();
    start = 1'b0;
    wait_done(lat, bcnt, ovl);
    check("busy start latency", 32'(lat), 32'd18);
    check("busy start result", {result_hi, result_lo}, 32'd733628);

    // Reset mid-operation aborts with no done and clears all outputs.
    launch(2'b10, 16'd50000, 16'd3);
    while (cyc - base < 8) advance();
    rst = 1'b1;
    advance();
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort hi", 32'(result_hi), 32'd0);
    check("abort lo", 32'(result_lo), 32'd0);
    check("abort div_zero", 32'(div_zero), 32'd0);
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      advance();
    end
    check("abort no done", 32'(nd), 32'd0);
    run_op("after abort", 2'b10, 16'd3473, 16'd147, 16'd92, 16'd23, 1'b0);

    // Back-to-back: run_op's launch accepts in the cycle right after done.
    run_op("b2b", 2'b11, 16'd100, 16'hFFF9, 16'd2, 16'hFFF2, 1'b0);
    check("b2b accept cycle", 32'(cyc - base), 32'd18);

    for (int i = 0; i < 60; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
      m   = model(rop, ra, rb);
      run_op($sformatf("rand%0d op%0d %h,%h", i, rop, ra, rb), rop, ra, rb,
             m[2*W-1:W], m[W-1:0], m[2*W]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
